// File: rtl/mem_stream_pkg.sv
// Shared encodings for the LBIST memory stream controller and the ORA compare block.
// Optional feature macro used by the controller: STREAM_LOOP_EN.
package mem_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    DRAIN,
    DONE
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/mem_stream_skid.sv
// Two-entry FIFO that absorbs registered read data from the word memory.
// Push and pop are ignored when full or empty respectively.
module mem_stream_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign full   = (r_cnt == 2'd2);
  assign empty  = (r_cnt == 2'd0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rp];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (w_pop)
        r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/mem_stream_ctrl.sv
// LBIST word-memory initiator: load words in, stream stored words out.
// STREAM_LOOP_EN adds a stop input and cyclic re-reading of the region.
module mem_stream_ctrl
  import mem_stream_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef STREAM_LOOP_EN
  input  logic                    stop,
`endif
  input  logic                    cmd_start,
  input  logic                    cmd_write,
  input  logic [ADDRESS_BITS-1:0] cmd_base,
  input  logic [ADDRESS_BITS:0]   cmd_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [WORD_SIZE-1:0]    wr_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_SIZE-1:0]    out_data,
  output logic                    mem_enable,
  output logic                    mem_rw,
  output logic [ADDRESS_BITS-1:0] mem_add,
  output logic [WORD_SIZE-1:0]    mem_data_w,
  input  logic [WORD_SIZE-1:0]    mem_data_r
);

  localparam int A = ADDRESS_BITS;
  localparam int W = WORD_SIZE;

  state_t       r_state;
  logic [A-1:0] r_addr;
  logic [A:0]   r_rem;
  logic         r_pend;
`ifdef STREAM_LOOP_EN
  logic [A-1:0] r_base;
  logic [A:0]   r_len;
`endif

  logic         w_stop;
  logic         w_wr_fire;
  logic         w_rd_issue;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [1:0]   w_cnt;
  logic [2:0]   w_occ;
  logic [W-1:0] w_head;
  logic         w_last;

`ifdef STREAM_LOOP_EN
  assign w_stop = stop;
`else
  assign w_stop = 1'b0;
`endif

  // Occupancy counts the in-flight read and discounts this cycle's pop,
  // which keeps a full-rate stream when the sink is always ready.
  assign w_pop      = !w_empty && out_ready;
  assign w_occ      = {2'b0, r_pend} + {1'b0, w_cnt} - {2'b0, w_pop};
  assign w_wr_fire  = (r_state == WR) && wr_valid;
  assign w_rd_issue = (r_state == RD) && !w_stop && !w_full
                      && (w_occ < 3'd2);
  assign w_last     = (r_rem == (A+1)'(1));

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign wr_ready   = (r_state == WR);
  assign mem_enable = w_wr_fire || w_rd_issue;
  assign mem_rw     = w_wr_fire;
  assign mem_add    = mem_enable ? r_addr : '0;
  assign mem_data_w = w_wr_fire ? wr_data : '0;
  assign out_valid  = !w_empty;
  assign out_data   = w_empty ? '0 : w_head;

  mem_stream_skid #(.W(W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_pend),
    .pop   (w_pop),
    .din   (mem_data_r),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_pend  <= 1'b0;
`ifdef STREAM_LOOP_EN
      r_base  <= '0;
      r_len   <= '0;
`endif
    end else begin
      r_pend <= w_rd_issue;
      unique case (r_state)
        IDLE: if (cmd_start) begin
          r_addr <= cmd_base;
          r_rem  <= cmd_len;
`ifdef STREAM_LOOP_EN
          r_base <= cmd_base;
          r_len  <= cmd_len;
`endif
          if (cmd_len == '0)
            r_state <= DONE;
          else if (cmd_write == MODE_WRITE)
            r_state <= WR;
          else
            r_state <= RD;
        end
        WR: if (w_wr_fire) begin
          r_addr <= r_addr + 1'b1;
          r_rem  <= r_rem - 1'b1;
          if (w_last)
            r_state <= DONE;
        end
        RD: begin
          if (w_rd_issue) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
          end
          if (w_stop)
            r_state <= DRAIN;
          else if (w_rd_issue && w_last) begin
`ifdef STREAM_LOOP_EN
            r_addr <= r_base;
            r_rem  <= r_len;
`else
            r_state <= DRAIN;
`endif
          end
        end
        DRAIN: if (!r_pend && w_empty)
          r_state <= DONE;
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
